// File: rtl/alu_flags.sv
// SM83 flag register stage behind the 8-bit ALU.
// It tracks Z/N/H/C, sequences the two-pass 16-bit adds and supplies the ALU carry-in.
module alu_flags #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [3:0] op,
  input  logic [7:0] res,
  input  logic       half_c,
  input  logic       carry,
  input  logic       f_we,
  input  logic [3:0] f_in,
  output logic [3:0] flags,
  output logic       cy_to_alu,
  output logic       wide,
  output logic       err
);

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_ADD      = 4'h1;
  localparam logic [3:0] OP_ADC      = 4'h2;
  localparam logic [3:0] OP_SUB      = 4'h3;
  localparam logic [3:0] OP_SBC      = 4'h4;
  localparam logic [3:0] OP_AND      = 4'h5;
  localparam logic [3:0] OP_ORXOR    = 4'h6;
  localparam logic [3:0] OP_CP       = 4'h7;
  localparam logic [3:0] OP_INC      = 4'h8;
  localparam logic [3:0] OP_DEC      = 4'h9;
  localparam logic [3:0] OP_ADD16_LO = 4'hA;
  localparam logic [3:0] OP_ADD16_HI = 4'hB;
  localparam logic [3:0] OP_SPE_LO   = 4'hC;
  localparam logic [3:0] OP_SPE_HI   = 4'hD;
  localparam logic [3:0] OP_SCF      = 4'hE;
  localparam logic [3:0] OP_CCF      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WIDE = 2'd1,
    ST_SPE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_flags;
  logic [3:0] w_flags_next;
  logic [3:0] w_op_flags;
  logic       r_lo_c;
  logic       w_lo_c_next;
  logic       r_err;
  logic       w_err_next;
  logic       w_zr;
  logic       w_is_hi;
  logic       w_hi_ok;

  assign w_zr    = (res == 8'h00);
  assign w_is_hi = (op == OP_ADD16_HI) || (op == OP_SPE_HI);
  assign w_hi_ok = ((op == OP_ADD16_HI) && (r_state == ST_WIDE)) ||
                   ((op == OP_SPE_HI)   && (r_state == ST_SPE));

  // A mismatched HI pass gets no carry-in: the low-byte carry belongs to another sequence.
  always_comb begin
    cy_to_alu = 1'b0;
    if (valid) begin
      if ((op == OP_ADC) || (op == OP_SBC)) begin
        cy_to_alu = r_flags[0];
      end else if (w_hi_ok) begin
        cy_to_alu = r_lo_c;
      end
    end
  end

  always_comb begin
    w_op_flags = r_flags;
    unique case (op)
      OP_NOP:                           w_op_flags = r_flags;
      OP_ADD, OP_ADC:                   w_op_flags = {w_zr, 1'b0, half_c, carry};
      OP_SUB, OP_SBC, OP_CP:            w_op_flags = {w_zr, 1'b1, half_c, carry};
      OP_AND:                           w_op_flags = {w_zr, 1'b0, 1'b1, 1'b0};
      OP_ORXOR:                         w_op_flags = {w_zr, 1'b0, 1'b0, 1'b0};
      OP_INC:                           w_op_flags = {w_zr, 1'b0, half_c, r_flags[0]};
      OP_DEC:                           w_op_flags = {w_zr, 1'b1, half_c, r_flags[0]};
      OP_ADD16_LO, OP_SPE_HI:           w_op_flags = r_flags;
      OP_ADD16_HI:                      w_op_flags = {r_flags[3], 1'b0, half_c, carry};
      OP_SPE_LO:                        w_op_flags = {1'b0, 1'b0, half_c, carry};
      OP_SCF:                           w_op_flags = {r_flags[3], 1'b0, 1'b0, 1'b1};
      OP_CCF:                           w_op_flags = {r_flags[3], 1'b0, 1'b0, ~r_flags[0]};
      default:                          w_op_flags = r_flags;
    endcase
  end

  // Sequencing: any op that does not complete the pending pass abandons it and raises err.
  always_comb begin
    w_flags_next = r_flags;
    w_state_next = r_state;
    w_lo_c_next  = r_lo_c;
    w_err_next   = r_err;
    if (valid) begin
      w_flags_next = w_op_flags;
      if (w_is_hi) begin
        if (!w_hi_ok) begin
          w_err_next = 1'b1;
        end
        w_state_next = ST_IDLE;
      end else begin
        if (r_state != ST_IDLE) begin
          w_err_next = 1'b1;
        end
        if (op == OP_ADD16_LO) begin
          w_state_next = ST_WIDE;
          w_lo_c_next  = carry;
        end else if (op == OP_SPE_LO) begin
          w_state_next = ST_SPE;
          w_lo_c_next  = carry;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
    end
    if (f_we) begin
      w_flags_next = f_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= RESET_FLAGS;
      r_state <= ST_IDLE;
      r_lo_c  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_flags <= w_flags_next;
      r_state <= w_state_next;
      r_lo_c  <= w_lo_c_next;
      r_err   <= w_err_next;
    end
  end

  assign flags = r_flags;
  assign wide  = (r_state != ST_IDLE);
  assign err   = r_err;

endmodule
